// File: rtl/trap_pkg.sv
// trap_pkg
// Shared types and constants for the trap controller.
//   state_e     : sequencer states (IDLE, HOLD, SWITCH, WAIT, REDIRECT)
//   kind_e      : sequence kind latched at entry (TRAP or RET)
//   CAUSE_INT_BIT and standard exception codes
//   irq_cause() : builds the 64-bit cause word for an interrupt code
package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SWITCH,
        ST_WAIT,
        ST_REDIRECT
    } state_e;

    typedef enum logic {
        KIND_TRAP,
        KIND_RET
    } kind_e;

    localparam int         CAUSE_INT_BIT = 63;
    localparam int         HOLDOFF_W     = 4;

    localparam logic [4:0] EXC_ILLEGAL   = 5'd2;
    localparam logic [4:0] EXC_BREAK     = 5'd3;
    localparam logic [4:0] EXC_ECALL_M   = 5'd11;

    // Interrupt cause: MSB set, 6-bit code in the low bits.
    function automatic logic [63:0] irq_cause(input logic [5:0] code);
        logic [63:0] c;
        c                = 64'(code);
        c[CAUSE_INT_BIT] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc
// Combinational lowest-index-wins priority encoder.
//   req_i   : request vector
//   valid_o : at least one request set
//   idx_o   : index of the lowest set request (0 when none)
module irq_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top so the lowest set index is written last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/trap_controller.sv
// trap_controller
// Sequences traps and trap returns into/out of the machine-mode CSR file:
// arbitrates exception / interrupt / return, stalls and drains the pipe,
// strobes CS with a stable CAUSE, then issues REDIRECT+FLUSH.
//   clk, rst_n       : clock, async active-low reset
//   exc_valid_i/code : synchronous exception from commit
//   irq_i, irq_en_i  : level interrupt lines and per-line enables
//   gie_i            : global interrupt enable
//   ret_valid_i      : trap-return at commit
//   drained_i        : pipeline empty
//   stall_o, cs_o, cause_o, redirect_o, flush_o, busy_o : registered decode
module trap_controller
    import trap_pkg::*;
#(
    parameter int N_IRQ       = 4,
    parameter int IRQ_BASE    = 16,
    parameter int RET_HOLDOFF = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exc_valid_i,
    input  logic [4:0]       exc_code_i,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic [N_IRQ-1:0] irq_en_i,
    input  logic             gie_i,
    input  logic             ret_valid_i,
    input  logic             drained_i,
    output logic             stall_o,
    output logic             cs_o,
    output logic [63:0]      cause_o,
    output logic             redirect_o,
    output logic             flush_o,
    output logic             busy_o
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    if (N_IRQ < 1 || N_IRQ > 16) begin : g_bad_nirq
        $error("trap_controller: N_IRQ must be 1..16");
    end
    if (IRQ_BASE + N_IRQ - 1 > 63) begin : g_bad_base
        $error("trap_controller: IRQ_BASE+N_IRQ-1 exceeds 6-bit cause code");
    end
    if (RET_HOLDOFF < 0 || RET_HOLDOFF > 15) begin : g_bad_holdoff
        $error("trap_controller: RET_HOLDOFF must be 0..15");
    end

    state_e                 state_q, state_d;
    kind_e                  kind_q, kind_d;
    logic [63:0]            cause_q, cause_d;
    logic [HOLDOFF_W-1:0]   holdoff_q, holdoff_d;

    logic [N_IRQ-1:0]       irq_elig;
    logic                   irq_vld;
    logic [IDX_W-1:0]       irq_idx;

    // Holdoff after a return masks interrupts only.
    assign irq_elig = irq_i & irq_en_i & {N_IRQ{gie_i}}
                    & {N_IRQ{holdoff_q == '0}};

    irq_prio_enc #(
        .N     (N_IRQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .req_i   (irq_elig),
        .valid_o (irq_vld),
        .idx_o   (irq_idx)
    );

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cause_d   = cause_q;
        holdoff_d = holdoff_q;

        if (state_q != ST_REDIRECT && holdoff_q != '0) begin
            holdoff_d = holdoff_q - 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (exc_valid_i) begin
                    state_d = ST_HOLD;
                    kind_d  = KIND_TRAP;
                    cause_d = 64'(exc_code_i);
                end else if (irq_vld) begin
                    state_d = ST_HOLD;
                    kind_d  = KIND_TRAP;
                    cause_d = irq_cause(6'(IRQ_BASE) + 6'(irq_idx));
                end else if (ret_valid_i) begin
                    // Return keeps the previous cause word; the CSR file
                    // decodes the return itself.
                    state_d = ST_HOLD;
                    kind_d  = KIND_RET;
                end
            end
            ST_HOLD:   if (drained_i) state_d = ST_SWITCH;
            ST_SWITCH: state_d = ST_WAIT;
            ST_WAIT:   state_d = ST_REDIRECT;
            ST_REDIRECT: begin
                state_d = ST_IDLE;
                if (kind_q == KIND_RET) holdoff_d = HOLDOFF_W'(RET_HOLDOFF);
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            kind_q    <= KIND_TRAP;
            cause_q   <= '0;
            holdoff_q <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cause_q   <= cause_d;
            holdoff_q <= holdoff_d;
        end
    end

    // Pure decode of registered state: no input reaches an output.
    assign busy_o     = (state_q != ST_IDLE);
    assign stall_o    = busy_o;
    assign cs_o       = (state_q == ST_SWITCH) && (kind_q == KIND_TRAP);
    assign redirect_o = (state_q == ST_REDIRECT);
    assign flush_o    = (state_q == ST_REDIRECT);
    assign cause_o    = cause_q;

endmodule

// File: doc/trap_controller.md
# trap_controller

Sequences every context switch into and out of the machine-mode CSR file. It arbitrates synchronous exceptions, level-sensitive interrupt lines and trap-return requests. It stalls and drains the pipeline, pulses the CSR file's CS strobe with a stable CAUSE word, and then issues a PC redirect and flush once the CSR file has produced the trap or return target. It sits between the core's execute/commit stage and the CSR file.

## Interface
- N_IRQ, 4: number of interrupt lines (1–16).
- IRQ_BASE, 16: cause code reported for IRQ[0]; IRQ[i] reports IRQ_BASE+i.
- RET_HOLDOFF, 1: cycles after a return redirect during which interrupts are ignored (0–15).
- CLK  input  1  clock; all state on rising edge.
- RESET_N  input  1  one clock; reset is asynchronous and active-low.
- EXC_VALID  input  1  synchronous exception reported by the commit stage.
- EXC_CODE  input  5  exception cause code; valid when EXC_VALID=1.
- IRQ  input  N_IRQ  level-sensitive interrupt pending lines.
- IRQ_EN  input  N_IRQ  per-line enable mask (mie image).
- GIE  input  1  global interrupt enable (mstatus.MIE image).
- RET_VALID  input  1  trap-return instruction at commit.
- DRAINED  input  1  pipeline empty, no instruction in flight.
- STALL  output  1  freeze fetch/issue.
- CS  output  1  one-cycle context-switch strobe to the CSR file.
- CAUSE  output  64  cause word to the CSR file.
- REDIRECT  output  1  one-cycle strobe: load PC from the CSR file's PC_OUT.
- FLUSH  output  1  one-cycle strobe, coincident with REDIRECT.
- BUSY  output  1  state≠IDLE.

## Operation
- Reset values: state IDLE; all outputs 0; CAUSE=0; holdoff counter 0; kind register=TRAP.
- Eligible interrupt: IRQ[i] & IRQ_EN[i] & GIE & (holdoff==0). The lowest index wins.
- Arbitration in IDLE, in priority order: EXC_VALID, then eligible interrupt, then RET_VALID. The loser gets no service this round; its source holds the request.
- Exception: CAUSE←{1'b0, 58'b0, EXC_CODE}. Interrupt: CAUSE←{1'b1, 57'b0, 6'(IRQ_BASE+i)}. Width: the sum is computed at 6 bits; IRQ_BASE+N_IRQ−1 must be ≤63, enforced by an elaboration-time check.
- CAUSE and kind (TRAP/RET) latch on the IDLE exit edge and hold until the return to IDLE. An interrupt deasserting after latch is still taken.
- States:
  - IDLE→HOLD on any accepted request.
  - HOLD: wait while DRAINED=0; →SWITCH when DRAINED=1.
  - SWITCH: CS=1 if kind=TRAP, CS=0 if kind=RET (the CSR file decodes the return itself); →WAIT.
  - WAIT: one cycle for the CSR file's registered PC_OUT; →REDIRECT.
  - REDIRECT: REDIRECT=FLUSH=1; if kind=RET, load holdoff←RET_HOLDOFF; →IDLE.
- Holdoff counter decrements in every non-REDIRECT cycle while nonzero. It saturates at 0 and blocks only interrupts; exceptions and returns are unaffected.
- STALL=1 in HOLD, SWITCH, WAIT and REDIRECT.
- Requests arriving while BUSY are ignored; sources hold them. An exception concurrent with the REDIRECT cycle is evaluated in the following IDLE cycle.
- Asynchronous reset mid-sequence forces IDLE and all outputs to 0 immediately. A partial CS does not occur because CS is registered.

## Timing
- All outputs are registered and decoded from state/latched registers; there are no combinational input→output paths.
- Request sampled in IDLE at edge k: STALL=1 from cycle k+1.
- With DRAINED=1 in cycle k+1: CS at k+2, REDIRECT/FLUSH at k+4, back in IDLE (STALL=0) at k+5. Minimum trap latency is 5 cycles, request to IDLE.
- Each cycle DRAINED stays 0 in HOLD adds one cycle.
- CS, REDIRECT and FLUSH are exactly one cycle wide per sequence.
- CAUSE is stable from k+1 through k+4, covering the CS cycle with margin.
- Back-to-back: a new request can be accepted in the first IDLE cycle (k+5).

## Structure
- Package trap_pkg holds:
  - state enum (IDLE, HOLD, SWITCH, WAIT, REDIRECT)
  - kind enum (TRAP, RET)
  - CAUSE_INT_BIT=63
  - standard exception code constants (ILLEGAL=2, BREAK=3, ECALL_M=11)
- Sub-module irq_prio_enc: combinational N_IRQ-bit lowest-index priority encoder with valid and index outputs.
- The FSM, cause latch and holdoff counter live in trap_controller.

## Test plan
- Reset: with RESET_N low, all outputs are 0. Release with EXC_VALID=1, EXC_CODE=2, DRAINED=1 → STALL at +1, CS at +2 with CAUSE=0x2, REDIRECT/FLUSH at +4, IDLE at +5.
- Interrupt priority: IRQ=4'b0110, IRQ_EN=4'b1111, GIE=1 → CAUSE=0x8000_0000_0000_0011 (line 1). With GIE=0, no response.
- Simultaneous: EXC_VALID (code 11) + IRQ[0] + RET_VALID in the same cycle → CAUSE=0xB and CS=1. Holding IRQ[0] afterwards gives a second sequence with CAUSE=0x8000…0010.
- Drain stall: DRAINED=0 for 3 cycles in HOLD → CS delayed to cycle k+5. CAUSE is unchanged even though IRQ drops mid-HOLD.
- Return + holdoff (RET_HOLDOFF=3): RET_VALID → CS never asserted, REDIRECT at +4. A pending enabled IRQ is taken only after the 3-cycle holdoff. An exception inside the holdoff is taken immediately.
- Async reset: assert RESET_N low in WAIT → outputs 0 without a clock edge; after release the FSM is in IDLE and no REDIRECT pulse occurs.
